// File: rtl/fire_pkg.sv
// fire_pkg: shared word format, per-fire channel table, FSM states and ReLU/saturate helper.
package fire_pkg;
  localparam int DW = 16;
  localparam int FRAC = 8;
  localparam int DEF_IN_CH = 8;
  localparam int DEF_OUT_CH = 64;
  localparam int DEF_LANES = 16;
  localparam int FIRE_IN_CH [8] = '{16, 16, 32, 32, 48, 48, 64, 64};
  localparam int FIRE_OUT_CH [8] = '{64, 64, 128, 128, 192, 192, 256, 256};
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_e;
  // Negative values become 0, anything that does not fit in DW-1 magnitude bits clamps to max.
  function automatic logic [DW-1:0] relu_sat(input logic [63:0] v);
    return v[63] ? '0 : (|v[62:DW-1]) ? {1'b0, {(DW-1){1'b1}}} : v[DW-1:0];
  endfunction
endpackage

// File: rtl/expand_mac_lane.sv
// expand_mac_lane: one signed MAC lane with bias add, Q8.8 rescale, ReLU and saturation.
module expand_mac_lane import fire_pkg::*; #(
  parameter int IN_CH = DEF_IN_CH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] bias,
  output logic [DW-1:0]        res
);
  localparam int AW = 2*DW + $clog2(IN_CH) + 1;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  always_comb begin
    prod = (2*DW)'(a) * (2*DW)'(w);
    acc_d = clr ? '0 : en ? acc_q + AW'(prod) : acc_q;
    sum = (acc_q + (AW'(bias) <<< FRAC)) >>> FRAC;
    res = relu_sat(64'(sum));
  end
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/expand1x1.sv
// expand1x1: fire expand 1x1 stage; per pixel, OUT_CH channels in GROUPS passes of LANES MAC lanes.
module expand1x1 import fire_pkg::*; #(
  parameter int IN_CH = DEF_IN_CH,
  parameter int OUT_CH = DEF_OUT_CH,
  parameter int LANES = DEF_LANES,
  parameter int PIXELS = 3025,
  localparam int GROUPS = OUT_CH / LANES,
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int WAW = (GROUPS*IN_CH > 1) ? $clog2(GROUPS*IN_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_data_valid,
  input  logic [DW*IN_CH-1:0]   datain,
  output logic                  o_ready,
  output logic [WAW-1:0]        w_addr,
  input  logic [DW*LANES-1:0]   w_data,
  output logic [GW-1:0]         b_addr,
  input  logic [DW*LANES-1:0]   b_data,
  output logic                  outvalid,
  output logic [DW*LANES-1:0]   outim,
  output logic [GW-1:0]         outgrp,
  output logic [31:0]           outaddr,
  output logic                  o_done
);
  localparam int KW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  state_e state_q;
  logic [GW-1:0] g_q;
  logic [KW-1:0] k_q, mk_q;
  logic [IN_CH-1:0][DW-1:0] pix_q;
  logic [LANES-1:0][DW-1:0] bias_q, res, outim_q;
  logic [31:0] pix_cnt_q, outaddr_q;
  logic [GW-1:0] outgrp_q;
  logic ready_q, outvalid_q, done_q, mac_clr, mac_en, last_grp, last_pix;
  assign mac_clr = (state_q == ACCUM) && (k_q == '0);
  assign mac_en = (state_q == DRAIN) || ((state_q == ACCUM) && (k_q != '0));
  assign last_grp = g_q == GW'(GROUPS-1);
  assign last_pix = pix_cnt_q == 32'(PIXELS-1);
  assign w_addr = WAW'(int'(g_q)*IN_CH + int'(k_q));
  assign b_addr = g_q;
  assign o_ready = ready_q;
  assign outvalid = outvalid_q;
  assign outim = outim_q;
  assign outgrp = outgrp_q;
  assign outaddr = outaddr_q;
  assign o_done = done_q;
  // The ROM answers one cycle late, so the MAC consumes the channel addressed on the previous cycle.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    expand_mac_lane #(.IN_CH(IN_CH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (mac_clr),
      .en   (mac_en),
      .a    (pix_q[mk_q]),
      .w    (w_data[l*DW +: DW]),
      .bias (bias_q[l]),
      .res  (res[l])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      k_q <= '0;
      mk_q <= '0;
      pix_q <= '0;
      bias_q <= '0;
      pix_cnt_q <= '0;
      ready_q <= 1'b0;
      outvalid_q <= 1'b0;
      done_q <= 1'b0;
      outim_q <= '0;
      outgrp_q <= '0;
      outaddr_q <= '0;
    end else begin
      mk_q <= k_q;
      outvalid_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_data_valid && ready_q) begin
            pix_q <= datain;
            g_q <= '0;
            k_q <= '0;
            ready_q <= 1'b0;
            state_q <= ACCUM;
          end else ready_q <= 1'b1;
        end
        ACCUM: begin
          k_q <= (k_q == KW'(IN_CH-1)) ? '0 : k_q + 1'b1;
          if (k_q == KW'(IN_CH-1)) state_q <= DRAIN;
        end
        DRAIN: begin
          bias_q <= b_data;
          state_q <= EMIT;
        end
        EMIT: begin
          outvalid_q <= 1'b1;
          outim_q <= res;
          outgrp_q <= g_q;
          outaddr_q <= pix_cnt_q;
          if (last_grp) begin
            g_q <= '0;
            ready_q <= 1'b1;
            done_q <= last_pix;
            pix_cnt_q <= last_pix ? '0 : pix_cnt_q + 1;
            state_q <= IDLE;
          end else begin
            g_q <= g_q + 1'b1;
            state_q <= ACCUM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_expand1x1.sv
// tb_expand1x1: directed scenarios for expand1x1 with registered weight/bias ROM models.
module tb_expand1x1;
  logic clk = 0, rst = 1, valid = 0, valid_f = 0;
  logic [127:0] datain = '0;
  logic [4:0] w_addr, w_addr_f;
  logic [1:0] b_addr, b_addr_f, outgrp, outgrp_f;
  logic [255:0] w_data, w_data_f, b_data, b_data_f, outim, outim_f;
  logic [31:0] outaddr, outaddr_f;
  logic o_ready, o_ready_f, outvalid, outvalid_f, o_done, o_done_f;
  int errors = 0, checks = 0, pix_n = 0;
  int addr_mode = 0;
  logic [15:0] w_val = 16'h0100, b_val = 16'h0000;

  always #5 clk = ~clk;

  expand1x1 dut (.clk(clk), .rst(rst), .i_data_valid(valid), .datain(datain), .o_ready(o_ready),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data), .outvalid(outvalid),
    .outim(outim), .outgrp(outgrp), .outaddr(outaddr), .o_done(o_done));

  expand1x1 #(.PIXELS(4)) dut_f (.clk(clk), .rst(rst), .i_data_valid(valid_f), .datain(datain),
    .o_ready(o_ready_f), .w_addr(w_addr_f), .w_data(w_data_f), .b_addr(b_addr_f), .b_data(b_data_f),
    .outvalid(outvalid_f), .outim(outim_f), .outgrp(outgrp_f), .outaddr(outaddr_f), .o_done(o_done_f));

  function automatic logic [255:0] rom_w(input logic [4:0] a);
    logic [255:0] r;
    for (int l = 0; l < 16; l++) r[l*16 +: 16] = (addr_mode != 0) ? 16'((int'(a) + 1) * 16) : w_val;
    return r;
  endfunction

  function automatic logic [255:0] rom_b(input logic [1:0] g);
    logic [255:0] r;
    for (int l = 0; l < 16; l++) r[l*16 +: 16] = (addr_mode != 0) ? 16'((l + int'(g)) * 64) : b_val;
    return r;
  endfunction

  always @(posedge clk) begin
    w_data <= rom_w(w_addr);
    w_data_f <= rom_w(w_addr_f);
    b_data <= rom_b(b_addr);
    b_data_f <= rom_b(b_addr_f);
  end

  task automatic send(input logic [127:0] d);
    @(negedge clk);
    datain = d;
    valid = 1;
    @(posedge clk);
    #1 valid = 0;
  endtask

  task automatic wait_valid(output int c, output bit to);
    c = 60;
    to = 1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (outvalid) begin
        c = i;
        to = 0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (o_ready !== 0 || outvalid !== 0 || outim !== '0 || outgrp !== 0 || outaddr !== 0 || o_done !== 0 ||
        w_addr !== 0 || b_addr !== 0 || o_ready_f !== 0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b im=%h grp=%0d addr=%0d done=%b wa=%0d ba=%0d, want all 0",
        o_ready, outvalid, outim, outgrp, outaddr, o_done, w_addr, b_addr);
    end
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1 checks++;
    if (o_ready !== 1 || o_ready_f !== 1) begin
      errors++;
      $display("FAIL reset_release: ready=%b ready_f=%b, want 1 1", o_ready, o_ready_f);
    end
  endtask

  task automatic test_unity();
    int c;
    bit to;
    addr_mode = 0; w_val = 16'h0100; b_val = 16'h0000;
    send({8{16'h0100}});
    for (int g = 0; g < 4; g++) begin
      wait_valid(c, to);
      checks++;
      if (to || c != 10 || outgrp !== 2'(g) || outaddr !== 32'(pix_n) || outim !== {16{16'h0800}}) begin
        errors++;
        $display("FAIL unity g%0d: cyc=%0d grp=%0d addr=%0d im=%h, want cyc=10 grp=%0d addr=%0d lanes 0800",
          g, c, outgrp, outaddr, outim, g, pix_n);
      end
    end
    pix_n++;
  endtask

  task automatic test_bias_relu();
    int c;
    bit to;
    logic [15:0] bv [2] = '{16'h0200, 16'h0A00};
    logic [15:0] ev [2] = '{16'h0000, 16'h0200};
    addr_mode = 0; w_val = 16'hFF00;
    for (int t = 0; t < 2; t++) begin
      b_val = bv[t];
      send({8{16'h0100}});
      for (int g = 0; g < 4; g++) begin
        wait_valid(c, to);
        checks++;
        if (to || c != 10 || outgrp !== 2'(g) || outaddr !== 32'(pix_n) || outim !== {16{ev[t]}}) begin
          errors++;
          $display("FAIL bias_relu t%0d g%0d: cyc=%0d grp=%0d addr=%0d im=%h, want lanes %h addr=%0d",
            t, g, c, outgrp, outaddr, outim, ev[t], pix_n);
        end
      end
      pix_n++;
    end
  endtask

  task automatic test_saturation();
    int c;
    bit to;
    addr_mode = 0; w_val = 16'h7FFF; b_val = 16'h7FFF;
    send({8{16'h7FFF}});
    for (int g = 0; g < 4; g++) begin
      wait_valid(c, to);
      checks++;
      if (to || c != 10 || outgrp !== 2'(g) || outim !== {16{16'h7FFF}}) begin
        errors++;
        $display("FAIL saturation g%0d: cyc=%0d grp=%0d im=%h, want lanes 7fff", g, c, outgrp, outim);
      end
    end
    pix_n++;
  endtask

  task automatic test_addressing();
    int c;
    bit to;
    logic [127:0] d;
    logic [255:0] ev;
    addr_mode = 1;
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = 16'((k + 1) * 256);
    send(d);
    for (int g = 0; g < 4; g++) begin
      for (int l = 0; l < 16; l++) ev[l*16 +: 16] = 16'(4672*g + 3264 + 64*l);
      wait_valid(c, to);
      checks++;
      if (to || c != 10 || outgrp !== 2'(g) || outaddr !== 32'(pix_n) || outim !== ev) begin
        errors++;
        $display("FAIL addressing g%0d: cyc=%0d grp=%0d addr=%0d im=%h, want %h", g, c, outgrp, outaddr, outim, ev);
      end
    end
    addr_mode = 0;
    pix_n++;
  endtask

  task automatic test_busy();
    int bad = 0, late = 0;
    w_val = 16'h0100; b_val = 16'h0000;
    @(negedge clk);
    datain = {8{16'h0100}};
    valid = 1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (outvalid !== (n % 10 == 0) || o_ready !== (n == 40)) bad++;
    end
    valid = 0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_hold: %0d cycles with wrong outvalid/o_ready, want 0", bad);
    end
    repeat (15) begin
      @(posedge clk);
      #1 if (outvalid || !o_ready) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL busy_reaccept: %0d cycles busy or pulsing after last emit, want 0", late);
    end
    pix_n++;
  endtask

  task automatic test_frame();
    int seen = 0, last = 0, stray = 0, gap;
    w_val = 16'h0100; b_val = 16'h0000;
    @(negedge clk);
    datain = {8{16'h0100}};
    valid_f = 1;
    for (int c = 1; c <= 300 && seen < 17; c++) begin
      @(posedge clk);
      #1;
      if (o_done_f && !outvalid_f) stray++;
      if (outvalid_f) begin
        gap = (seen % 4 == 0) ? 11 : 10;
        checks++;
        if (outgrp_f !== 2'(seen % 4) || outaddr_f !== 32'((seen / 4) % 4) || o_done_f !== (seen == 15) ||
            (seen > 0 && c - last != gap) || outim_f !== {16{16'h0800}}) begin
          errors++;
          $display("FAIL frame pulse%0d: grp=%0d addr=%0d done=%b gap=%0d, want grp=%0d addr=%0d done=%b gap=%0d",
            seen, outgrp_f, outaddr_f, o_done_f, c - last, seen % 4, (seen / 4) % 4, seen == 15, gap);
        end
        last = c;
        seen++;
      end
    end
    valid_f = 0;
    checks++;
    if (seen != 17 || stray != 0) begin
      errors++;
      $display("FAIL frame_count: pulses=%0d stray_done=%0d, want 17 0", seen, stray);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    send({8{16'h0100}});
    repeat (14) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1 checks++;
    if (o_ready !== 0 || outvalid !== 0 || outim !== '0 || outaddr !== 0) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b valid=%b im=%h addr=%0d, want 0", o_ready, outvalid, outim, outaddr);
    end
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1 checks++;
    if (o_ready !== 1) begin
      errors++;
      $display("FAIL reset_mid_ready: ready=%b, want 1", o_ready);
    end
    repeat (40) begin
      @(posedge clk);
      #1 if (outvalid) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_mid_abort: %0d outvalid pulses after reset, want 0", extra);
    end
    pix_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unity();
    test_bias_relu();
    test_saturation();
    test_addressing();
    test_busy();
    test_frame();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
